// File: rtl/mean.sv
// mean -- block (decimating) averager.
//   Accumulates N consecutive accepted samples and emits their floor mean as a
//   single output sample, so the output rate is the input rate divided by N.
//   Samples are treated as two's-complement when SIG=1 and as unsigned when
//   SIG=0.
// Parameters:
//   WIDTH        sample width
//   DEPTH_WIDTH  accumulator width, at least WIDTH + $clog2(N)
//   N            samples per average (power of two, >= 1)
//   SIG          1: signed samples, 0: unsigned samples
// Ports:
//   clk     rising-edge clock
//   rstn    asynchronous active-low reset
//   i_vld   input sample valid (always accepted)
//   i_data  input sample
//   o_vld   one-cycle pulse marking a new mean on o_data
//   o_data  latest mean, held until the next block completes
module mean #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WIDTH = 33,
  parameter int N           = 2,
  parameter int SIG         = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  localparam int SHIFT = $clog2(N);
  localparam int CW    = (SHIFT < 1) ? 1 : SHIFT;

  if (N < 1 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("mean: N must be a power of two >= 1");
  end
  if (DEPTH_WIDTH < WIDTH + SHIFT) begin : g_bad_depth
    $error("mean: DEPTH_WIDTH must be >= WIDTH + $clog2(N)");
  end

  logic [DEPTH_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   o_vld_q, o_vld_d;
  logic [WIDTH-1:0]       o_data_q, o_data_d;

  logic [DEPTH_WIDTH-1:0] ext_data;
  logic [DEPTH_WIDTH-1:0] sum;

  always_comb begin
    if (SIG != 0) begin
      ext_data = DEPTH_WIDTH'($signed(i_data));
    end else begin
      ext_data = DEPTH_WIDTH'(i_data);
    end
    sum = acc_q + ext_data;

    acc_d    = acc_q;
    cnt_d    = cnt_q;
    o_vld_d  = 1'b0;
    o_data_d = o_data_q;

    if (i_vld) begin
      if (cnt_q == CW'(N - 1)) begin
        // Block complete: publish the mean and restart from an empty sum so the
        // next accepted sample is the first of a fresh block.
        if (SIG != 0) begin
          o_data_d = WIDTH'($signed(sum) >>> SHIFT);
        end else begin
          o_data_d = WIDTH'(sum >> SHIFT);
        end
        o_vld_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      o_vld_q  <= 1'b0;
      o_data_q <= '0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      o_vld_q  <= o_vld_d;
      o_data_q <= o_data_d;
    end
  end

  assign o_vld  = o_vld_q;
  assign o_data = o_data_q;

endmodule

// File: tb/tb_mean.sv
// tb_mean -- self-checking bench for mean.
//   Four instances share one stimulus stream: N=2 signed, N=2 unsigned,
//   N=4 signed and N=1 signed. A behavioural model per instance averages each
//   completed block with integer floor division and queues the expected output;
//   a negedge monitor pops and compares when the DUT pulses o_vld.
module tb_mean;

  localparam int ND = 4;
  localparam int NS [ND] = '{2, 2, 4, 1};
  localparam int SG [ND] = '{1, 0, 1, 1};

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  logic        clk;
  logic        rstn;
  logic        i_vld;
  logic [31:0] i_data;
  logic        o_vld_a  [ND];
  logic [31:0] o_data_a [ND];

  int unsigned cyc;
  int          checks;
  int          failures;

  exp_t        sbq  [ND][$];
  longint      blk  [ND][$];
  logic [31:0] held [ND];

  mean #(.WIDTH(32), .DEPTH_WIDTH(33), .N(2), .SIG(1)) u_s2 (
    .clk(clk), .rstn(rstn), .i_vld(i_vld), .i_data(i_data),
    .o_vld(o_vld_a[0]), .o_data(o_data_a[0]));
  mean #(.WIDTH(32), .DEPTH_WIDTH(33), .N(2), .SIG(0)) u_u2 (
    .clk(clk), .rstn(rstn), .i_vld(i_vld), .i_data(i_data),
    .o_vld(o_vld_a[1]), .o_data(o_data_a[1]));
  mean #(.WIDTH(32), .DEPTH_WIDTH(34), .N(4), .SIG(1)) u_s4 (
    .clk(clk), .rstn(rstn), .i_vld(i_vld), .i_data(i_data),
    .o_vld(o_vld_a[2]), .o_data(o_data_a[2]));
  mean #(.WIDTH(32), .DEPTH_WIDTH(32), .N(1), .SIG(1)) u_p1 (
    .clk(clk), .rstn(rstn), .i_vld(i_vld), .i_data(i_data),
    .o_vld(o_vld_a[3]), .o_data(o_data_a[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Model: collect a block, then floor(sum / N) using plain integer arithmetic.
  task automatic model_push(input logic [31:0] d);
    longint v, s, q;
    exp_t   e;
    for (int i = 0; i < ND; i++) begin
      if (SG[i] != 0) v = longint'($signed(d));
      else            v = longint'({32'b0, d});
      blk[i].push_back(v);
      if (blk[i].size() == NS[i]) begin
        s = 0;
        foreach (blk[i][k]) s += blk[i][k];
        q = s / NS[i];
        if ((s % NS[i]) != 0 && s < 0) q -= 1;
        e.due  = cyc + 1;
        e.data = q[31:0];
        sbq[i].push_back(e);
        blk[i].delete();
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < ND; i++) begin
      logic due_now;
      exp_t e;
      due_now = (sbq[i].size() != 0) && (sbq[i][0].due == cyc);
      chk($sformatf("o_vld[%0d]", i), {31'b0, o_vld_a[i]}, {31'b0, due_now});
      if (due_now) begin
        e = sbq[i].pop_front();
        held[i] = e.data;
        if (o_vld_a[i]) chk($sformatf("o_data[%0d]", i), o_data_a[i], e.data);
      end else begin
        chk($sformatf("hold[%0d]", i), o_data_a[i], held[i]);
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] d);
    @(negedge clk);
    #2;
    i_vld  = v;
    i_data = d;
    if (v) model_push(d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rstn  = 1'b0;
    i_vld = 1'b0;
    for (int i = 0; i < ND; i++) begin
      blk[i].delete();
      sbq[i].delete();
      held[i] = '0;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_vld", {31'b0, o_vld_a[0]}, 32'd0);
      chk("rst_data", o_data_a[0], 32'd0);
    end
    @(negedge clk);
    #2;
    rstn = 1'b1;
  endtask

  vec_t tbl[$];

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rstn     = 1'b0;
    i_vld    = 1'b0;
    i_data   = '0;
    for (int i = 0; i < ND; i++) held[i] = '0;

    // Expected columns refer to the N=2 signed instance, one edge after the row.
    tbl.push_back('{1'b1, 32'd1,        1'b0, 32'h0});
    tbl.push_back('{1'b1, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFF});
    tbl.push_back('{1'b1, 32'd3,        1'b0, 32'hFFFFFFFF});
    tbl.push_back('{1'b1, 32'd4,        1'b1, 32'd3});
    tbl.push_back('{1'b1, 32'd4,        1'b0, 32'd3});
    tbl.push_back('{1'b1, 32'd4,        1'b1, 32'd4});
    tbl.push_back('{1'b1, 32'd5,        1'b0, 32'd4});
    tbl.push_back('{1'b0, 32'hDEAD,     1'b0, 32'd4});
    tbl.push_back('{1'b0, 32'hBEEF,     1'b0, 32'd4});
    tbl.push_back('{1'b1, 32'd7,        1'b1, 32'd6});
    tbl.push_back('{1'b1, 32'hFFFFFFFF, 1'b0, 32'd6});
    tbl.push_back('{1'b1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF});

    do_reset();

    for (int r = 0; r < tbl.size(); r++) begin
      step(tbl[r].v, tbl[r].d);
      chk($sformatf("tbl%0d_vld", r), {31'b0, o_vld_a[0]}, {31'b0, tbl[r].ev});
      chk($sformatf("tbl%0d_data", r), o_data_a[0], tbl[r].ed);
    end

    // Partial block dropped by reset; the next block averages 2 and 4.
    do_reset();
    step(1'b1, 32'd9);
    chk("part_no_vld", {31'b0, o_vld_a[0]}, 32'd0);
    do_reset();
    step(1'b1, 32'd2);
    step(1'b1, 32'd4);
    chk("after_rst_vld", {31'b0, o_vld_a[0]}, 32'd1);
    chk("after_rst_data", o_data_a[0], 32'd3);

    // N=4 floor of -1.25.
    do_reset();
    step(1'b1, 32'hFFFFFFFF);
    step(1'b1, 32'hFFFFFFFF);
    step(1'b1, 32'hFFFFFFFF);
    step(1'b1, 32'hFFFFFFFE);
    chk("n4_vld", {31'b0, o_vld_a[2]}, 32'd1);
    chk("n4_data", o_data_a[2], 32'hFFFFFFFE);
    chk("n2_floor_data", o_data_a[0], 32'hFFFFFFFE);

    // Random gapped traffic checked by the scoreboard.
    for (int k = 0; k < 60; k++) begin
      step(1'($urandom_range(0, 1)), $urandom);
    end
    step(1'b0, '0);
    step(1'b0, '0);
    @(negedge clk);
    #2;
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("drain[%0d]", i), sbq[i].size(), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
